// File: rtl/id_ex_stage_pkg.sv
// Shared ALU-op package: function codes, forwarding-select enum and the
// ID/EX control bundle used by the ID/EX pipeline stage.
package id_ex_stage_pkg;

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_AND  = 4'd2;
  localparam logic [3:0] FUNC_OR   = 4'd3;
  localparam logic [3:0] FUNC_XOR  = 4'd4;
  localparam logic [3:0] FUNC_SLL  = 4'd5;
  localparam logic [3:0] FUNC_SRL  = 4'd6;
  localparam logic [3:0] FUNC_SRA  = 4'd7;
  localparam logic [3:0] FUNC_BEQ  = 4'd8;
  localparam logic [3:0] FUNC_BNE  = 4'd9;
  localparam logic [3:0] FUNC_BLT  = 4'd10;
  localparam logic [3:0] FUNC_BGE  = 4'd11;
  localparam logic [3:0] FUNC_SLT  = 4'd12;
  localparam logic [3:0] FUNC_SLTU = 4'd13;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // All-zero value of this bundle is the pipeline bubble.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       is_jal;
    logic       is_jalr;
    logic       is_halt;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic branch_taken(input logic [3:0] op,
                                        input logic       eq,
                                        input logic       lt_signed);
    logic taken;
    taken = 1'b0;
    case (op)
      FUNC_BEQ: taken = eq;
      FUNC_BNE: taken = ~eq;
      FUNC_BLT: taken = lt_signed;
      FUNC_BGE: taken = ~lt_signed;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/id_ex_stage_forwarding_unit.sv
// Operand forwarding selector for one EX source register: the MEM result wins
// over the WB result, and register 0 is never forwarded.
module forwarding_unit
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  fwd_sel_e w_sel;
  logic     w_mem_hit;
  logic     w_wb_hit;

  assign w_mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
  assign w_wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  always_comb begin
    w_sel = FWD_REG;
    if (w_mem_hit) begin
      w_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      w_sel = FWD_WB;
    end
  end

  always_comb begin
    fwd_data = reg_data;
    case (w_sel)
      FWD_MEM: fwd_data = mem_data;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush/load-use bubble handling, operand
// forwarding, ALU input muxing and branch-condition evaluation.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_is_jal,
  input  logic            id_is_jalr,
  input  logic            id_is_halt,
  input  logic            id_alu_src_imm,
  input  logic            id_alu_src_pc,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_is_halt,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in_1,
  output logic [XLEN-1:0] alu_in_2,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_br_cond,
  output logic            load_use_stall
);

  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;

  ctrl_t           w_id_ctrl;
  logic            w_load_use;
  logic [RA_W-1:0] w_rs_idx [2];
  logic [XLEN-1:0] w_rs_reg [2];
  logic [XLEN-1:0] w_rs_fwd [2];

  assign w_id_ctrl = '{
    valid:       id_valid,
    reg_write:   id_reg_write,
    mem_read:    id_mem_read,
    mem_write:   id_mem_write,
    mem_to_reg:  id_mem_to_reg,
    is_jal:      id_is_jal,
    is_jalr:     id_is_jalr,
    is_halt:     id_is_halt,
    alu_src_imm: id_alu_src_imm,
    alu_src_pc:  id_alu_src_pc,
    alu_op:      id_alu_op
  };

  // A load in EX whose destination is read by the instruction in ID.
  assign w_load_use = r_ctrl.valid && r_ctrl.mem_read && id_valid &&
                      (r_rd != '0) && ((r_rd == id_rs1) || (r_rd == id_rs2));
  assign load_use_stall = w_load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (flush) begin
      r_ctrl <= '0;
      r_rd   <= '0;
    end else if (!stall) begin
      if (w_load_use) begin
        r_ctrl <= '0;
        r_rd   <= '0;
      end else begin
        r_ctrl     <= w_id_ctrl;
        r_pc       <= id_pc;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
      end
    end
  end

  assign w_rs_idx[0] = r_rs1;
  assign w_rs_idx[1] = r_rs2;
  assign w_rs_reg[0] = r_rs1_data;
  assign w_rs_reg[1] = r_rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forwarding_unit #(
      .XLEN (XLEN),
      .RA_W (RA_W)
    ) u_fwd (
      .ex_rs         (w_rs_idx[gi]),
      .reg_data      (w_rs_reg[gi]),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_data      (mem_fwd_data),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_fwd_data),
      .fwd_data      (w_rs_fwd[gi])
    );
  end

  // Control outputs are qualified by valid so a bubble can never commit.
  assign ex_valid      = r_ctrl.valid;
  assign ex_reg_write  = r_ctrl.valid & r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.valid & r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.valid & r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.valid & r_ctrl.mem_to_reg;
  assign ex_is_jal     = r_ctrl.valid & r_ctrl.is_jal;
  assign ex_is_jalr    = r_ctrl.valid & r_ctrl.is_jalr;
  assign ex_is_halt    = r_ctrl.valid & r_ctrl.is_halt;
  assign alu_op        = r_ctrl.alu_op;
  assign ex_pc         = r_pc;
  assign ex_rd         = r_rd;

  assign alu_in_1      = r_ctrl.alu_src_pc  ? r_pc  : w_rs_fwd[0];
  assign alu_in_2      = r_ctrl.alu_src_imm ? r_imm : w_rs_fwd[1];
  assign ex_store_data = w_rs_fwd[1];

  assign ex_br_cond = r_ctrl.valid &&
                      branch_taken(r_ctrl.alu_op,
                                   (w_rs_fwd[0] == w_rs_fwd[1]),
                                   ($signed(w_rs_fwd[0]) < $signed(w_rs_fwd[1])));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven capture/forwarding/branch
// vectors through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct {
    logic [7:0]  ctl;  // valid,reg_write,mem_read,mem_write,mem_to_reg,jal,jalr,halt
    logic        src_imm;
    logic        src_pc;
    logic [3:0]  op;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
  } id_t;

  typedef struct {
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wd;
  } fwd_t;

  typedef struct {
    logic [7:0]  ctl;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc, a1, a2, sd;
    logic        br;
  } exp_t;

  typedef struct {
    string name;
    id_t   id;
    fwd_t  f;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_is_jal, id_is_jalr, id_is_halt, id_alu_src_imm, id_alu_src_pc;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_is_jal, ex_is_jalr, ex_is_halt;
  logic [31:0] ex_pc, alu_in_1, alu_in_2, ex_store_data;
  logic [4:0]  ex_rd;
  logic [3:0]  alu_op;
  logic        ex_br_cond, load_use_stall;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  string name_q[$];
  vec_t tbl[14];

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_is_jal(id_is_jal),
    .id_is_jalr(id_is_jalr), .id_is_halt(id_is_halt), .id_alu_src_imm(id_alu_src_imm),
    .id_alu_src_pc(id_alu_src_pc), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_is_halt(ex_is_halt), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .ex_store_data(ex_store_data), .ex_br_cond(ex_br_cond),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] out_ctl();
    return {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
            ex_is_jal, ex_is_jalr, ex_is_halt};
  endfunction

  function automatic id_t mk_id(logic [7:0] ctl, logic si, logic sp, logic [3:0] op,
                                logic [31:0] pc, logic [31:0] rs1d, logic [31:0] rs2d,
                                logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd);
    id_t v;
    v.ctl = ctl; v.src_imm = si; v.src_pc = sp; v.op = op; v.pc = pc;
    v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    return v;
  endfunction

  function automatic fwd_t mk_fwd(logic mrw, logic [4:0] mrd, logic [31:0] md,
                                  logic wrw, logic [4:0] wrd, logic [31:0] wd);
    fwd_t f;
    f.mrw = mrw; f.mrd = mrd; f.md = md; f.wrw = wrw; f.wrd = wrd; f.wd = wd;
    return f;
  endfunction

  function automatic exp_t mk_exp(logic [7:0] ctl, logic [3:0] op, logic [4:0] rd,
                                  logic [31:0] pc, logic [31:0] a1, logic [31:0] a2,
                                  logic [31:0] sd, logic br);
    exp_t e;
    e.ctl = ctl; e.op = op; e.rd = rd; e.pc = pc; e.a1 = a1; e.a2 = a2; e.sd = sd; e.br = br;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, want);
    end
  endtask

  task automatic drive_id(input id_t v);
    {id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
     id_is_jal, id_is_jalr, id_is_halt} = v.ctl;
    id_alu_src_imm = v.src_imm; id_alu_src_pc = v.src_pc; id_alu_op = v.op;
    id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
  endtask

  task automatic drive_fwd(input fwd_t f);
    mem_reg_write = f.mrw; mem_rd = f.mrd; mem_fwd_data = f.md;
    wb_reg_write = f.wrw; wb_rd = f.wrd; wb_fwd_data = f.wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string n, input exp_t e);
    chk({n, ".ctl"}, {24'd0, out_ctl()}, {24'd0, e.ctl});
    chk({n, ".op"},  {28'd0, alu_op}, {28'd0, e.op});
    chk({n, ".rd"},  {27'd0, ex_rd}, {27'd0, e.rd});
    chk({n, ".pc"},  ex_pc, e.pc);
    chk({n, ".a1"},  alu_in_1, e.a1);
    chk({n, ".a2"},  alu_in_2, e.a2);
    chk({n, ".sd"},  ex_store_data, e.sd);
    chk({n, ".br"},  {31'd0, ex_br_cond}, {31'd0, e.br});
    $display("txn %-10s ctl=%02h op=%0d rd=%0d a1=%08h a2=%08h sd=%08h br=%0b",
             n, out_ctl(), alu_op, ex_rd, alu_in_1, alu_in_2, ex_store_data, ex_br_cond);
  endtask

  fwd_t none;
  id_t  idle;
  exp_t zero_e;

  initial begin
    none   = mk_fwd(0, 0, 0, 0, 0, 0);
    idle   = mk_id(8'h00, 0, 0, FUNC_ADD, 0, 0, 0, 0, 0, 0, 0);
    zero_e = mk_exp(8'h00, 4'd0, 5'd0, 0, 0, 0, 0, 1'b0);

    tbl[0]  = '{"capture", mk_id(8'hC0, 1, 0, FUNC_ADD, 32'h100, 5, 9, 7, 1, 0, 2), none,
                mk_exp(8'hC0, FUNC_ADD, 2, 32'h100, 5, 7, 9, 0)};
    tbl[1]  = '{"fwd_mem", mk_id(8'hC0, 0, 0, FUNC_SUB, 32'h104, 32'hAA, 5, 0, 3, 0, 4),
                mk_fwd(1, 3, 32'h11, 1, 3, 32'h22),
                mk_exp(8'hC0, FUNC_SUB, 4, 32'h104, 32'h11, 5, 5, 0)};
    tbl[2]  = '{"fwd_wb", mk_id(8'hC0, 0, 0, FUNC_SUB, 32'h104, 32'hAA, 5, 0, 3, 0, 4),
                mk_fwd(0, 3, 32'h11, 1, 3, 32'h22),
                mk_exp(8'hC0, FUNC_SUB, 4, 32'h104, 32'h22, 5, 5, 0)};
    tbl[3]  = '{"fwd_x0", mk_id(8'hC0, 0, 0, FUNC_ADD, 32'h108, 32'h33, 6, 0, 0, 0, 4),
                mk_fwd(1, 0, 32'h11, 1, 0, 32'h22),
                mk_exp(8'hC0, FUNC_ADD, 4, 32'h108, 32'h33, 6, 6, 0)};
    tbl[4]  = '{"fwd_rs2", mk_id(8'hC0, 1, 0, FUNC_OR, 32'h10C, 32'h10, 1, 4, 1, 7, 8),
                mk_fwd(0, 0, 0, 1, 7, 32'h77),
                mk_exp(8'hC0, FUNC_OR, 8, 32'h10C, 32'h10, 4, 32'h77, 0)};
    tbl[5]  = '{"src_pc", mk_id(8'hC0, 1, 1, FUNC_ADD, 32'h200, 32'h99, 2, 8, 1, 2, 9), none,
                mk_exp(8'hC0, FUNC_ADD, 9, 32'h200, 32'h200, 8, 2, 0)};
    tbl[6]  = '{"blt", mk_id(8'h80, 0, 0, FUNC_BLT, 32'h300, 32'hFFFF_FFFF, 1, 0, 5, 6, 0), none,
                mk_exp(8'h80, FUNC_BLT, 0, 32'h300, 32'hFFFF_FFFF, 1, 1, 1)};
    tbl[7]  = '{"bge", mk_id(8'h80, 0, 0, FUNC_BGE, 32'h304, 32'hFFFF_FFFF, 1, 0, 5, 6, 0), none,
                mk_exp(8'h80, FUNC_BGE, 0, 32'h304, 32'hFFFF_FFFF, 1, 1, 0)};
    tbl[8]  = '{"beq", mk_id(8'h80, 0, 0, FUNC_BEQ, 32'h308, 32'hFFFF_FFFF, 1, 0, 5, 6, 0), none,
                mk_exp(8'h80, FUNC_BEQ, 0, 32'h308, 32'hFFFF_FFFF, 1, 1, 0)};
    tbl[9]  = '{"bne", mk_id(8'h80, 0, 0, FUNC_BNE, 32'h30C, 32'hFFFF_FFFF, 1, 0, 5, 6, 0), none,
                mk_exp(8'h80, FUNC_BNE, 0, 32'h30C, 32'hFFFF_FFFF, 1, 1, 1)};
    tbl[10] = '{"bne_inval", mk_id(8'h40, 0, 0, FUNC_BNE, 32'h310, 32'hFFFF_FFFF, 1, 0, 5, 6, 3), none,
                mk_exp(8'h00, FUNC_BNE, 3, 32'h310, 32'hFFFF_FFFF, 1, 1, 0)};
    tbl[11] = '{"beq_fwd", mk_id(8'h80, 0, 0, FUNC_BEQ, 32'h314, 3, 4, 0, 5, 6, 0),
                mk_fwd(1, 6, 3, 0, 0, 0),
                mk_exp(8'h80, FUNC_BEQ, 0, 32'h314, 3, 3, 3, 1)};
    tbl[12] = '{"store", mk_id(8'h90, 1, 0, FUNC_ADD, 32'h318, 32'h1000, 32'hDEAD, 32'h10, 1, 8, 0), none,
                mk_exp(8'h90, FUNC_ADD, 0, 32'h318, 32'h1000, 32'h10, 32'hDEAD, 0)};
    tbl[13] = '{"jal", mk_id(8'hC4, 1, 1, FUNC_ADD, 32'h31C, 0, 0, 4, 0, 0, 1), none,
                mk_exp(8'hC4, FUNC_ADD, 1, 32'h31C, 32'h31C, 4, 0, 0)};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(idle); drive_fwd(none);
    tick(); tick();
    check_all("reset", zero_e);
    chk("reset.lus", {31'd0, load_use_stall}, 32'd0);
    reset = 1'b0;

    // Table vectors: expected record queued when the ID inputs are driven,
    // popped and compared once the stage has registered them.
    foreach (tbl[i]) begin
      drive_fwd(none);
      drive_id(tbl[i].id);
      exp_q.push_back(tbl[i].e);
      name_q.push_back(tbl[i].name);
      tick();
      drive_fwd(tbl[i].f);
      #1;
      check_all(name_q.pop_front(), exp_q.pop_front());
    end
    drive_fwd(none);

    // Load-use: lw x4 in EX, dependent reader of x4 in ID.
    drive_id(mk_id(8'hE8, 1, 0, FUNC_ADD, 32'h400, 32'h2000, 0, 0, 0, 0, 4));
    tick();
    drive_id(mk_id(8'hC0, 0, 0, FUNC_ADD, 32'h404, 1, 32'h44, 0, 1, 4, 5));
    #1;
    chk("lu.stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu.bubble", {24'd0, out_ctl()}, 32'd0);
    chk("lu.bubble_rd", {27'd0, ex_rd}, 32'd0);
    chk("lu.release", {31'd0, load_use_stall}, 32'd0);
    $display("txn lu_bubble ex_valid=%0b lus=%0b", ex_valid, load_use_stall);
    tick();
    drive_fwd(mk_fwd(0, 0, 0, 1, 4, 32'h55));
    #1;
    chk("lu.capture", {31'd0, ex_valid}, 32'd1);
    chk("lu.rd", {27'd0, ex_rd}, 32'd5);
    chk("lu.a2_wbfwd", alu_in_2, 32'h55);
    $display("txn lu_dep ex_valid=%0b rd=%0d a2=%08h", ex_valid, ex_rd, alu_in_2);
    drive_fwd(none);

    // A load to x0 never raises the hazard.
    drive_id(mk_id(8'hE8, 1, 0, FUNC_ADD, 32'h408, 0, 0, 0, 0, 0, 0));
    tick();
    drive_id(mk_id(8'hC0, 0, 0, FUNC_ADD, 32'h40C, 0, 0, 0, 0, 0, 6));
    #1;
    chk("lu.x0", {31'd0, load_use_stall}, 32'd0);
    $display("txn lu_x0 lus=%0b", load_use_stall);

    // Stall holds for three edges; flush with stall then bubbles.
    drive_id(mk_id(8'hC0, 0, 0, FUNC_XOR, 32'h500, 32'h123, 32'h456, 0, 1, 2, 9));
    tick();
    stall = 1'b1;
    drive_id(mk_id(8'hE8, 1, 1, FUNC_SUB, 32'h600, 32'h999, 32'h888, 32'h77, 3, 3, 10));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.ctl", {24'd0, out_ctl()}, 32'h0000_00C0);
      chk("stall.rd", {27'd0, ex_rd}, 32'd9);
      chk("stall.a1", alu_in_1, 32'h123);
      chk("stall.pc", ex_pc, 32'h500);
      $display("txn stall%0d ctl=%02h rd=%0d a1=%08h", k, out_ctl(), ex_rd, alu_in_1);
    end
    flush = 1'b1;
    tick();
    chk("flush.ctl", {24'd0, out_ctl()}, 32'd0);
    chk("flush.rd", {27'd0, ex_rd}, 32'd0);
    chk("flush.op", {28'd0, alu_op}, 32'd0);
    $display("txn flush ctl=%02h rd=%0d op=%0d", out_ctl(), ex_rd, alu_op);
    flush = 1'b0; stall = 1'b0;

    // Reset mid-stream while stalled clears everything.
    drive_id(mk_id(8'hDC, 1, 0, FUNC_BNE, 32'h700, 32'h31, 32'h32, 32'h33, 1, 2, 11));
    tick();
    chk("pre_reset.valid", {31'd0, ex_valid}, 32'd1);
    reset = 1'b1; stall = 1'b1;
    tick();
    check_all("reset_mid", zero_e);
    chk("reset_mid.lus", {31'd0, load_use_stall}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
